// File: rtl/adder_ctrl_pkg.sv
// Shared types, widths and BCD helpers for the switch-adder entry sequencer.
package adder_ctrl_pkg;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned OPERAND_W  = 7;
    localparam int unsigned SUM_W      = 8;
    localparam int unsigned BCD_STEPS  = 8;
    localparam int unsigned STEP_W     = 4;
    localparam int unsigned BCD_DIGITS = 3;
    localparam int unsigned DABBLE_W   = BCD_DIGITS * BCD_W + SUM_W;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        CONVERT = 2'd2,
        SHOW    = 2'd3
    } state_t;

    typedef struct packed {
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] unit;
    } operand_bcd_t;

    typedef struct packed {
        logic [BCD_W-1:0] hundred;
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] unit;
    } sum_bcd_t;

    // Operand is clamped to 99, so tens and units each fit one BCD digit.
    function automatic operand_bcd_t to_bcd(input logic [OPERAND_W-1:0] v);
        operand_bcd_t r;
        r.tens = BCD_W'(v / OPERAND_W'(10));
        r.unit = BCD_W'(v % OPERAND_W'(10));
        return r;
    endfunction

    // One double-dabble step: add 3 to every BCD digit >= 5, then shift left.
    function automatic logic [DABBLE_W-1:0] dabble_step(input logic [DABBLE_W-1:0] v);
        logic [DABBLE_W-1:0] t;
        t = v;
        for (int d = 0; d < int'(BCD_DIGITS); d++) begin
            if (t[SUM_W + d*BCD_W +: BCD_W] >= BCD_W'(5)) begin
                t[SUM_W + d*BCD_W +: BCD_W] = t[SUM_W + d*BCD_W +: BCD_W] + BCD_W'(3);
            end
        end
        return {t[DABBLE_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/adder_entry_sequencer_button_debouncer.sv
// Button conditioner: 2-FF synchroniser, stability counter and rising-edge press pulse.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_ff0;
    logic             sync_ff1;
    logic [CNT_W-1:0] cnt;

    // Counter runs only while the synced level disagrees with the accepted level,
    // so any bounce back to the accepted level restarts the stability window.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff0 <= 1'b0;
            sync_ff1 <= 1'b0;
            cnt      <= '0;
            level    <= 1'b0;
            press    <= 1'b0;
        end else begin
            sync_ff0 <= btn_raw;
            sync_ff1 <= sync_ff0;
            press    <= 1'b0;
            if (sync_ff1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_ff1;
                press <= sync_ff1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/adder_entry_sequencer.sv
// Operand entry sequencer for the switch adder: debounced buttons, clamped operands,
// serial binary-to-BCD conversion of the sum and registered digits for the displays.
module adder_entry_sequencer
    import adder_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned OPERAND_MAX     = 99
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPERAND_W-1:0] switchs,
    input  logic                 btn_enter,
    input  logic                 btn_clear,
    output logic [BCD_W-1:0]     a_tens,
    output logic [BCD_W-1:0]     a_unit,
    output logic [BCD_W-1:0]     b_tens,
    output logic [BCD_W-1:0]     b_unit,
    output logic [BCD_W-1:0]     sum_hundred,
    output logic [BCD_W-1:0]     sum_tens,
    output logic [BCD_W-1:0]     sum_unit,
    output logic [1:0]           state_o,
    output logic                 sum_valid
);

    localparam logic [OPERAND_W-1:0] OP_MAX    = OPERAND_W'(OPERAND_MAX);
    localparam logic [STEP_W-1:0]    STEP_LAST = STEP_W'(BCD_STEPS - 1);

    state_t                state_q, state_d;
    logic [OPERAND_W-1:0]  sw_ff0, sw_ff1;
    logic [OPERAND_W-1:0]  clamp_c;
    logic [OPERAND_W-1:0]  a_q, b_q;
    operand_bcd_t          a_bcd_q, b_bcd_q;
    sum_bcd_t              sum_bcd_q;
    logic [DABBLE_W-1:0]   dabble_q, dabble_next_c;
    logic [STEP_W-1:0]     step_q;
    logic                  sum_valid_q;
    logic                  enter_press, clear_press;
    logic                  enter_level, clear_level;
    logic                  track_a_c, track_b_c, start_cvt_c, step_cvt_c, finish_cvt_c, leave_show_c;
    logic                  unused_levels;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_enter),
        .level   (enter_level),
        .press   (enter_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_clear),
        .level   (clear_level),
        .press   (clear_press)
    );

    // Debounced levels are not needed here; only the press pulses drive the sequencer.
    assign unused_levels = enter_level ^ clear_level;

    // Switch synchroniser
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_ff0 <= '0;
            sw_ff1 <= '0;
        end else begin
            sw_ff0 <= switchs;
            sw_ff1 <= sw_ff0;
        end
    end

    assign clamp_c       = (sw_ff1 > OP_MAX) ? OP_MAX : sw_ff1;
    assign dabble_next_c = dabble_step(dabble_q);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ENTER_A;
        else     state_q <= state_d;
    end

    // Next state and datapath strobes; clear outranks enter in every state.
    always_comb begin
        state_d      = state_q;
        track_a_c    = 1'b0;
        track_b_c    = 1'b0;
        start_cvt_c  = 1'b0;
        step_cvt_c   = 1'b0;
        finish_cvt_c = 1'b0;
        leave_show_c = 1'b0;
        if (clear_press) begin
            state_d = ENTER_A;
        end else begin
            case (state_q)
                ENTER_A: begin
                    track_a_c = !enter_press;
                    if (enter_press) state_d = ENTER_B;
                end
                ENTER_B: begin
                    track_b_c = !enter_press;
                    if (enter_press) begin
                        start_cvt_c = 1'b1;
                        state_d     = CONVERT;
                    end
                end
                CONVERT: begin
                    step_cvt_c = 1'b1;
                    if (step_q == STEP_LAST) begin
                        finish_cvt_c = 1'b1;
                        state_d      = SHOW;
                    end
                end
                SHOW: begin
                    if (enter_press) begin
                        leave_show_c = 1'b1;
                        state_d      = ENTER_A;
                    end
                end
                default: state_d = ENTER_A;
            endcase
        end
    end

    // Operands, conversion shift register and registered display digits.
    always_ff @(posedge clk) begin
        if (rst || clear_press) begin
            a_q         <= '0;
            b_q         <= '0;
            a_bcd_q     <= '0;
            b_bcd_q     <= '0;
            sum_bcd_q   <= '0;
            dabble_q    <= '0;
            step_q      <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            if (track_a_c) a_q <= clamp_c;
            if (track_b_c) b_q <= clamp_c;
            a_bcd_q <= to_bcd(a_q);
            b_bcd_q <= to_bcd(b_q);
            if (start_cvt_c) begin
                dabble_q    <= DABBLE_W'(SUM_W'(a_q) + SUM_W'(b_q));
                step_q      <= '0;
                sum_valid_q <= 1'b0;
            end
            if (step_cvt_c) begin
                dabble_q <= dabble_next_c;
                step_q   <= step_q + STEP_W'(1);
            end
            // Digits are only published once the final shift has completed.
            if (finish_cvt_c) begin
                sum_bcd_q.hundred <= dabble_next_c[SUM_W + 2*BCD_W +: BCD_W];
                sum_bcd_q.tens    <= dabble_next_c[SUM_W + BCD_W +: BCD_W];
                sum_bcd_q.unit    <= dabble_next_c[SUM_W +: BCD_W];
                sum_valid_q       <= 1'b1;
            end
            if (leave_show_c) sum_valid_q <= 1'b0;
        end
    end

    assign a_tens      = a_bcd_q.tens;
    assign a_unit      = a_bcd_q.unit;
    assign b_tens      = b_bcd_q.tens;
    assign b_unit      = b_bcd_q.unit;
    assign sum_hundred = sum_bcd_q.hundred;
    assign sum_tens    = sum_bcd_q.tens;
    assign sum_unit    = sum_bcd_q.unit;
    assign state_o     = state_q;
    assign sum_valid   = sum_valid_q;

endmodule
